qlm_dot_acc: RTL and testbench
==============================

// Module: qlm_dot_acc
// PURPOSE
//  Sits directly downstream of the 16x16 approximate log multiplier. Consumes its 32-bit ones'-complement
//  signed products over a valid/ready stream and accumulates a run of LEN products into a wide
//  two's-complement sum (dot product). Presents the result on a valid/ready output.
//  Performs the ones'- to two's-complement correction that the multiplier leaves to downstream logic.
// PARAMETERS
//  ACC_W  40  accumulator/result width in bits; legal range 33..64
//  LEN_W  8   width of run-length and beat counter; max run = 2^LEN_W-1 products
// PORTS
//  clk        in   1      clock; all state changes on the rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      start a run; sampled only in IDLE
//  len        in   LEN_W  number of products in the run; sampled together with start
//  in_valid   in   1      in_prod is valid
//  in_ready   out  1      block accepts in_prod this cycle
//  in_prod    in   32     multiplier product: ones'-complement signed (negative = ~|p|)
//  out_valid  out  1      out_sum/out_ovf are valid
//  out_ready  in   1      consumer takes the result
//  out_sum    out  ACC_W  two's-complement accumulated sum
//  out_ovf    out  1      sticky: the signed accumulator overflowed during this run
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE. in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0. Counter=0.
//   If rst asserts mid-run, the partial sum is discarded and no result is produced.
//  FSM states: IDLE, ACC, DONE. State and all outputs are registered, except in_ready, which decodes state.
//   IDLE: in_ready=0. When start=1, latch len, clear the sum, out_ovf and the counter.
//    If len==0, go to DONE; the result is sum=0.
//    Otherwise go to ACC.
//   ACC: in_ready=1. A beat is accepted when in_valid and in_ready are both 1.
//    Each accepted beat: sum <= sum + sext(in_prod) + in_prod[31]. The carry-in converts ones' to two's
//    complement, so 32'hFFFF_FFF9 contributes -6. 32'h0 contributes 0.
//    The counter increments on each accepted beat. The beat that makes counter==len moves the FSM to DONE.
//    No throughput gap: one product per cycle is sustained.
//   DONE: out_valid=1. out_sum and out_ovf are held stable until out_ready=1. That handshake cycle moves
//    the FSM to IDLE. out_valid falls the next cycle.
//  start while busy is ignored; len is not re-sampled. A start in the same cycle as the DONE handshake is
//   ignored, so there is a minimum of one IDLE cycle between runs.
//  in_valid while not in ACC is ignored; nothing is consumed.
//  Latency: the result is valid 1 cycle after the last beat is accepted, or 1 cycle after start when len==0.
//  Overflow: a signed overflow on any beat sets out_ovf, which stays set until the next start.
//   The detection reference is the ACC_W-bit signed add.
//  out_sum updates only when the run completes. The internal accumulator is separate from out_sum.
// CONFIGURATION
//  QLM_ACC_SAT_EN defined: on overflow the sum saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
//   The sum stays saturated until a later beat brings it back in range.
//  QLM_ACC_SAT_EN undefined: the sum wraps modulo 2^ACC_W.
//  out_ovf behaves identically in both builds.
// TESTING
//  1. Reset mid-ACC (after 2 of len=4 beats) -> all outputs 0 asynchronously; state IDLE; no out_valid.
//  2. len=3; in_prod=32'd10, 32'hFFFF_FFF9, 32'd5, back-to-back -> out_sum=9, out_ovf=0, out_valid 1 cycle
//     after beat 3.
//  3. len=0 with start -> out_valid=1 next cycle, out_sum=0. Hold out_ready=0 for 5 cycles -> out_sum stable;
//     busy=1 throughout.
//  4. len=2; in_valid toggling 1,0,0,1 and start pulsed during ACC -> exactly 2 beats consumed;
//     the extra start is ignored.
//  5. ACC_W=33, len=3, 3x 32'h7FFF_FFFF -> wrap build: out_sum=-2147483651, out_ovf=1;
//     SAT build: out_sum=33'h0_FFFF_FFFF, out_ovf=1.
//  6. Two runs back-to-back with out_ready tied 1 -> one IDLE bubble; second result is not polluted
//     by the first run's sum or out_ovf.

Source files
------------

// File: rtl/qlm_dot_acc_if.sv
// Stream bundle between the log multiplier, the dot-product accumulator and its consumer.
// master: the environment driving products in and taking the result out.
// slave : the accumulator itself.
interface qlm_dot_acc_if #(
  parameter int unsigned ACC_W = 40
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_ovf
  );

endinterface

// File: rtl/qlm_dot_acc.sv
// Dot-product accumulator for the 16x16 approximate log multiplier.
// Takes ones'-complement signed 32-bit products, fixes them up to two's complement with a carry-in,
// and sums a run of len products into an ACC_W-bit signed result.
// Optional build macro: QLM_ACC_SAT_EN (saturate on overflow instead of wrapping).
module qlm_dot_acc #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  qlm_dot_acc_if.slave     bus,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] raw_sum;
  logic             beat_ovf;
  logic [ACC_W-1:0] acc_next;

  // Two's-complement value of the current product plus the signed add and its overflow.
  // ACC_W >= 33 means sext(p) + p[31] can never itself overflow.
  always_comb begin
    addend   = {{(ACC_W-32){bus.in_prod[31]}}, bus.in_prod} + {{(ACC_W-1){1'b0}}, bus.in_prod[31]};
    raw_sum  = acc_q + addend;
    beat_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (raw_sum[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef QLM_ACC_SAT_EN
    if (beat_ovf) begin
      // Both operands share a sign on overflow, so acc_q's sign picks the rail.
      acc_next = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_next = raw_sum;
    end
`else
    acc_next = raw_sum;
`endif
  end

  // Next-state and next-output decode of the run controller.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d = len;
          cnt_d = '0;
          acc_d = '0;
          ovf_d = 1'b0;
          if (len == '0) begin
            state_d = StDone;
            sum_d   = '0;
          end else begin
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (bus.in_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q + LEN_W'(1);
          ovf_d = ovf_q | beat_ovf;
          if (cnt_d == len_q) begin
            state_d = StDone;
            sum_d   = acc_next;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    valid_d = (state_d == StDone);
    busy_d  = (state_d != StIdle);
  end

  // State and registered outputs; reset discards any partial run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_qlm_dot_acc.sv
// Self-checking bench for qlm_dot_acc, built with ACC_W=33 so that overflow is reachable within
// a 255-product run. Expected results come from a plain signed-integer model of the run.
module tb_qlm_dot_acc;

  localparam int unsigned ACC_W = 33;
  localparam int unsigned LEN_W = 8;
  localparam longint MaxV = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
  localparam longint MinV = -(64'sd1 <<< (ACC_W - 1));
  localparam longint ModV = 64'sd1 <<< ACC_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;

  qlm_dot_acc_if #(.ACC_W(ACC_W)) bus ();

  qlm_dot_acc #(
    .ACC_W(ACC_W),
    .LEN_W(LEN_W)
  ) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .len  (len),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] prods[$];
  int          vpat[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Ones'-complement product to its signed integer value.
  function automatic longint prod_val(input logic [31:0] p);
    logic [63:0] mag;
    if (p[31]) begin
      mag = {32'd0, ~p};
      return -longint'(mag);
    end
    mag = {32'd0, p};
    return longint'(mag);
  endfunction

  // Reference: integer sum of the run, with wrap or clamp whenever it leaves the ACC_W range.
  task automatic model(output logic [ACC_W-1:0] s, output logic o);
    longint acc;
    acc = 0;
    o   = 1'b0;
    foreach (prods[i]) begin
      acc += prod_val(prods[i]);
      if (acc > MaxV) begin
        o = 1'b1;
`ifdef QLM_ACC_SAT_EN
        acc = MaxV;
`else
        acc -= ModV;
`endif
      end else if (acc < MinV) begin
        o = 1'b1;
`ifdef QLM_ACC_SAT_EN
        acc = MinV;
`else
        acc += ModV;
`endif
      end
    end
    s = acc[ACC_W-1:0];
  endtask

  function automatic logic [31:0] rand_prod();
    logic [31:0] k;
    k = $urandom_range(1000);
    case ($urandom_range(4))
      0: return $urandom();
      1: return k;
      2: return ~k;
      3: return 32'h7FFF_FFFF;
      default: return 32'h8000_0000;
    endcase
  endfunction

  // One full run using prods[]; chain keeps out_ready high and raises start on the handshake.
  task automatic run(input string tag, input int gap_pct, input int hold, input bit extra_start,
                     input bit chain);
    logic [ACC_W-1:0] es;
    logic             eo;
    int               l;
    int               idx;
    int               n;
    bit               v;
    bit               hs;
    bit               exact;
    l     = prods.size();
    exact = (gap_pct == 0) && (vpat.size() == 0);
    model(es, eo);
    start = 1'b1;
    len   = LEN_W'(l);
    cyc();
    start = 1'b0;
    check({tag, ".busy_run"}, 64'(busy), 64'd1);
    if (l > 0) check({tag, ".in_ready_acc"}, 64'(bus.in_ready), 64'd1);
    idx = 0;
    n   = 0;
    while (idx < l && n < 2000) begin
      if (vpat.size() > 0) v = (vpat.pop_front() != 0);
      else v = ($urandom_range(99) >= gap_pct);
      bus.in_valid = v;
      bus.in_prod  = v ? prods[idx] : $urandom();
      if (extra_start) begin
        start = 1'b1;
        len   = 8'd9;
      end
      hs = v && bus.in_ready;
      cyc();
      if (hs) idx++;
      n++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, ".beats"}, 64'(idx), 64'(l));
    if (exact) check({tag, ".cycles"}, 64'(n), 64'(l));
    check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, ".out_sum"}, 64'(bus.out_sum), 64'(es));
    check({tag, ".out_ovf"}, 64'(bus.out_ovf), 64'(eo));
    check({tag, ".in_ready_done"}, 64'(bus.in_ready), 64'd0);
    if (hold > 0) begin
      repeat (hold) begin
        bus.in_valid = 1'b1;
        bus.in_prod  = $urandom();
        cyc();
        check({tag, ".hold_sum"}, 64'(bus.out_sum), 64'(es));
      end
      bus.in_valid = 1'b0;
      check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".hold_ovf"}, 64'(bus.out_ovf), 64'(eo));
      check({tag, ".hold_busy"}, 64'(busy), 64'd1);
    end
    bus.out_ready = 1'b1;
    if (chain) begin
      start = 1'b1;
      len   = 8'd1;
    end
    cyc();
    start = 1'b0;
    check({tag, ".valid_fall"}, 64'(bus.out_valid), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    if (!chain) bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    len           = '0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd0);
    check("rst.out_sum", 64'(bus.out_sum), 64'd0);
    check("rst.out_ovf", 64'(bus.out_ovf), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    #10 rst = 1'b0;
    cyc();

    // Mixed-sign run; 32'hFFFF_FFF9 is -6.
    prods = '{32'd10, 32'hFFFF_FFF9, 32'd5};
    run("basic", 0, 0, 1'b0, 1'b0);
    check("basic.value", 64'(bus.out_sum), 64'd9);

    // Reset after two of four beats: outputs clear at once and no result appears.
    start = 1'b1;
    len   = 8'd4;
    cyc();
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_prod  = 32'd100;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    check("midrst.out_sum", 64'(bus.out_sum), 64'd0);
    check("midrst.out_ovf", 64'(bus.out_ovf), 64'd0);
    check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst.in_ready", 64'(bus.in_ready), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    #2 rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) cyc();
    check("midrst.no_result", 64'(bus.out_valid), 64'd0);
    check("midrst.idle", 64'(busy), 64'd0);

    // Empty run held for five cycles.
    prods = '{32'd3};
    run("pre0", 0, 0, 1'b0, 1'b0);
    prods = {};
    run("len0", 0, 5, 1'b0, 1'b0);

    // Gappy valid pattern with start asserted throughout the run.
    prods = '{32'd1234, ~32'd34};
    vpat  = '{1, 0, 0, 1};
    run("gaps", 0, 2, 1'b1, 1'b0);

    // Positive overflow at the top of a 33-bit accumulator.
    prods = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run("ovf", 0, 0, 1'b0, 1'b0);

    // Back-to-back runs with out_ready tied high; the second must start clean.
    prods = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run("chainA", 0, 0, 1'b0, 1'b1);
    prods = '{32'd7, ~32'd2};
    run("chainB", 0, 0, 1'b0, 1'b1);
    prods = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd1};
    run("chainC", 0, 0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    cyc();

    // Randomized runs.
    for (int r = 0; r < 12; r++) begin
      int l;
      l     = $urandom_range(1, 30);
      prods = {};
      for (int i = 0; i < l; i++) prods.push_back(rand_prod());
      run($sformatf("rand%0d", r), 30, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
